// File: rtl/time_ctrl_if.sv
// time_ctrl_if -- bundle between the clock/calendar set controller and the
// downstream time counters.
//
//   btn_mode/btn_up/btn_down : debounced button levels, active-high
//   mode_24h                 : 1 = 24 h display format, 0 = 12 h
//   second..year             : current counter values fed back to the controller
//   en/inc/dec               : per-field strobes, bit 0 = second .. bit 5 = year
//   day_num                  : day maximum for the current month/year
//   hour_num                 : hour maximum for the current format
//   mode_sel                 : 0 = running, 1..6 = field being set
//
// master = controller side, slave = counters/buttons side.
interface time_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       mode_24h;
  logic [5:0] second;
  logic [5:0] minute;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [5:0] en;
  logic [5:0] inc;
  logic [5:0] dec;
  logic [4:0] day_num;
  logic [4:0] hour_num;
  logic [2:0] mode_sel;

  modport master (
    input  btn_mode, btn_up, btn_down, mode_24h,
    input  second, minute, hour, day, month, year,
    output en, inc, dec, day_num, hour_num, mode_sel
  );

  modport slave (
    output btn_mode, btn_up, btn_down, mode_24h,
    output second, minute, hour, day, month, year,
    input  en, inc, dec, day_num, hour_num, mode_sel
  );
endinterface

// File: rtl/time_ctrl.sv
// time_ctrl -- controller for a seconds..year clock/calendar.
//
// In RUN it divides clk down to a 1 s tick and issues a rippled increment
// strobe set to the external counters. btn_mode walks through the six set
// states, where btn_up/btn_down step the selected field. After a month/year
// change (or leaving hour set with an out-of-range hour) a CLAMP state pulls
// the day (or hour) counter back into range.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous, active-low reset
//   bus      : time_ctrl_if.master (buttons, counter values in; strobes,
//              day_num, hour_num, mode_sel out)
module time_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  time_ctrl_if.master bus
);

  localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);

  // Encoding chosen so a SET state's value equals its mode_sel code.
  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_SEC   = 3'd1,
    S_MIN   = 3'd2,
    S_HOUR  = 3'd3,
    S_DAY   = 3'd4,
    S_MON   = 3'd5,
    S_YEAR  = 3'd6,
    S_CLAMP = 3'd7
  } state_t;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
      4'd2:                                       d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                                    d = 5'd28;
    endcase
    return d;
  endfunction

  state_t        state_q, state_d;
  state_t        ret_q, ret_d;
  logic          clamp_hour_q, clamp_hour_d;
  logic          wait_q, wait_d;
  logic [CW-1:0] tick_cnt_q;
  logic [5:0]    en_q, en_d;
  logic [5:0]    inc_q, inc_d;
  logic [5:0]    dec_q, dec_d;
  logic [2:0]    btn_lvl_q;
  logic [2:0]    edge_q;

  logic          tick;
  logic          mode_e, up_e, dn_e;
  logic          up_ok, dn_ok;
  logic [4:0]    day_num;
  logic [4:0]    hour_num;
  logic          sec_max, min_max, hr_max, day_max, mon_max;
  logic          clamp_need;
  logic [5:0]    carry;
  logic [2:0]    fld;

  assign day_num  = days_in_month(bus.month, bus.year);
  assign hour_num = bus.mode_24h ? 5'd23 : 5'd11;

  assign mode_e = edge_q[2];
  assign up_e   = edge_q[1];
  assign dn_e   = edge_q[0];
  // Simultaneous up and down cancel each other.
  assign up_ok  = up_e & ~dn_e;
  assign dn_ok  = dn_e & ~up_e;

  assign tick = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);

  assign sec_max = (bus.second == 6'd59);
  assign min_max = (bus.minute == 6'd59);
  assign hr_max  = (bus.hour   == hour_num);
  assign day_max = (bus.day    == day_num);
  assign mon_max = (bus.month  == 4'd12);

  assign clamp_need = clamp_hour_q ? (bus.hour > hour_num) : (bus.day > day_num);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    clamp_hour_d = clamp_hour_q;
    wait_d       = wait_q;
    en_d         = '0;
    inc_d        = '0;
    dec_d        = '0;
    carry        = '0;
    fld          = 3'(state_q) - 3'd1;

    case (state_q)
      S_RUN: begin
        // Carries ripple from the pre-tick values so every field that rolls
        // over strobes in the same cycle.
        if (tick) begin
          carry[0] = 1'b1;
          carry[1] = sec_max;
          carry[2] = carry[1] & min_max;
          carry[3] = carry[2] & hr_max;
          carry[4] = carry[3] & day_max;
          carry[5] = carry[4] & mon_max;
          en_d     = carry;
          inc_d    = carry;
        end
        if (mode_e) begin
          state_d = S_SEC;
        end
      end

      S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR: begin
        if (mode_e) begin
          if ((state_q == S_HOUR) && (bus.hour > hour_num)) begin
            // Format switched while setting: pull the hour down before
            // moving on to the day field.
            state_d      = S_CLAMP;
            ret_d        = S_DAY;
            clamp_hour_d = 1'b1;
            wait_d       = 1'b0;
          end else if (state_q == S_YEAR) begin
            state_d = S_RUN;
          end else begin
            state_d = state_t'(3'(state_q) + 3'd1);
          end
        end else if (up_ok || dn_ok) begin
          en_d[fld]  = 1'b1;
          inc_d[fld] = up_ok;
          dec_d[fld] = dn_ok;
          if ((state_q == S_MON) || (state_q == S_YEAR)) begin
            // The month/year strobe lands next cycle, so the day check has
            // to wait one cycle before it sees the new day_num.
            state_d      = S_CLAMP;
            ret_d        = state_q;
            clamp_hour_d = 1'b0;
            wait_d       = 1'b1;
          end
        end
      end

      S_CLAMP: begin
        // Alternate strobe / settle so each decision uses the updated value.
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (clamp_need) begin
          if (clamp_hour_q) begin
            en_d[2]  = 1'b1;
            dec_d[2] = 1'b1;
          end else begin
            en_d[3]  = 1'b1;
            dec_d[3] = 1'b1;
          end
          wait_d = 1'b1;
        end else begin
          state_d = ret_q;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Button level history follows the pins even in reset so a button held
  // through reset does not look like a fresh press afterwards.
  always_ff @(posedge clk) begin
    btn_lvl_q <= {bus.btn_mode, bus.btn_up, bus.btn_down};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      ret_q        <= S_RUN;
      clamp_hour_q <= 1'b0;
      wait_q       <= 1'b0;
      tick_cnt_q   <= '0;
      en_q         <= '0;
      inc_q        <= '0;
      dec_q        <= '0;
      edge_q       <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      clamp_hour_q <= clamp_hour_d;
      wait_q       <= wait_d;
      en_q         <= en_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      edge_q       <= {bus.btn_mode, bus.btn_up, bus.btn_down} & ~btn_lvl_q;
      // Divider only runs while staying in RUN; any entry restarts it at 0.
      if ((state_q != S_RUN) || (state_d != S_RUN)) begin
        tick_cnt_q <= '0;
      end else if (tick) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + CW'(1);
      end
    end
  end

  assign bus.en       = en_q;
  assign bus.inc      = inc_q;
  assign bus.dec      = dec_q;
  assign bus.day_num  = day_num;
  assign bus.hour_num = hour_num;
  assign bus.mode_sel = (state_q == S_CLAMP) ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_time_ctrl.sv
// tb_time_ctrl -- directed bench for time_ctrl with TICK_DIV = 4 and a
// behavioural model of the downstream counters.
module tb_time_ctrl;

  logic clk;
  logic reset_n;
  int   passed;
  int   failed;
  int   total;

  time_ctrl_if bus ();

  time_ctrl #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counters: load port for directed setup, otherwise follow the
  // strobes with wrap between reset value and maximum.
  logic       ld;
  logic [5:0] ld_sec, ld_min;
  logic [4:0] ld_hour, ld_day;
  logic [3:0] ld_mon;
  logic [6:0] ld_year;

  function automatic logic [7:0] stepv(input logic [7:0] v, input logic e, input logic i,
                                       input logic [7:0] lo, input logic [7:0] hi);
    if (!e) return v;
    if (i)  return (v == hi) ? lo : v + 8'd1;
    return (v == lo) ? hi : v - 8'd1;
  endfunction

  always @(posedge clk) begin
    if (ld) begin
      bus.second <= ld_sec;
      bus.minute <= ld_min;
      bus.hour   <= ld_hour;
      bus.day    <= ld_day;
      bus.month  <= ld_mon;
      bus.year   <= ld_year;
    end else begin
      bus.second <= 6'(stepv(8'(bus.second), bus.en[0], bus.inc[0], 8'd0, 8'd59));
      bus.minute <= 6'(stepv(8'(bus.minute), bus.en[1], bus.inc[1], 8'd0, 8'd59));
      bus.hour   <= 5'(stepv(8'(bus.hour),   bus.en[2], bus.inc[2], 8'd0, 8'(bus.hour_num)));
      bus.day    <= 5'(stepv(8'(bus.day),    bus.en[3], bus.inc[3], 8'd1, 8'(bus.day_num)));
      bus.month  <= 4'(stepv(8'(bus.month),  bus.en[4], bus.inc[4], 8'd1, 8'd12));
      bus.year   <= 7'(stepv(8'(bus.year),   bus.en[5], bus.inc[5], 8'd0, 8'd99));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
    step(1);
  endtask

  task automatic pulse_up();
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_up = 1'b0;
    step(1);
  endtask

  task automatic load(input int s, input int mi, input int h, input int d, input int mo, input int y);
    ld_sec  = 6'(s);
    ld_min  = 6'(mi);
    ld_hour = 5'(h);
    ld_day  = 5'(d);
    ld_mon  = 4'(mo);
    ld_year = 7'(y);
  endtask

  task automatic do_reset();
    ld      = 1'b1;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    ld      = 1'b0;
  endtask

  initial begin
    int decs;
    int k;
    passed = 0;
    failed = 0;
    total  = 0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.mode_24h = 1'b1;
    reset_n      = 1'b0;
    ld           = 1'b1;
    load(59, 59, 23, 31, 12, 99);

    // Reset state, then full rollover 23:59:59 31-Dec-99
    step(2);
    chk("rst_mode_sel", 32'(bus.mode_sel), 0);
    chk("rst_en", 32'(bus.en), 0);
    chk("rst_inc", 32'(bus.inc), 0);
    chk("rst_dec", 32'(bus.dec), 0);
    reset_n = 1'b1;
    ld      = 1'b0;
    step(3);
    chk("pre_tick_en", 32'(bus.en), 0);
    step(1);
    chk("roll_en", 32'(bus.en), 32'h3F);
    chk("roll_inc", 32'(bus.inc), 32'h3F);
    chk("roll_dec", 32'(bus.dec), 0);
    step(1);
    chk("roll_en_off", 32'(bus.en), 0);
    chk("roll_sec", 32'(bus.second), 0);
    chk("roll_hour", 32'(bus.hour), 0);
    chk("roll_day", 32'(bus.day), 1);
    chk("roll_month", 32'(bus.month), 1);
    chk("roll_year", 32'(bus.year), 0);

    // Partial carry in 12 h mode: 11:59:59 on 3 Mar
    bus.mode_24h = 1'b0;
    load(59, 59, 11, 3, 3, 7);
    do_reset();
    step(4);
    chk("c12_en", 32'(bus.en), 32'h0F);
    chk("c12_inc", 32'(bus.inc), 32'h0F);
    step(1);
    chk("c12_hour", 32'(bus.hour), 0);
    chk("c12_day", 32'(bus.day), 4);

    // day_num / hour_num
    ld = 1'b1;
    load(0, 0, 0, 1, 2, 4);  step(1); chk("dn_feb_y4", 32'(bus.day_num), 29);
    load(0, 0, 0, 1, 2, 5);  step(1); chk("dn_feb_y5", 32'(bus.day_num), 28);
    load(0, 0, 0, 1, 2, 0);  step(1); chk("dn_feb_y0", 32'(bus.day_num), 29);
    load(0, 0, 0, 1, 4, 5);  step(1); chk("dn_apr", 32'(bus.day_num), 30);
    load(0, 0, 0, 1, 1, 5);  step(1); chk("dn_jan", 32'(bus.day_num), 31);
    load(0, 0, 0, 1, 11, 5); step(1); chk("dn_nov", 32'(bus.day_num), 30);
    bus.mode_24h = 1'b0; step(1); chk("hn_12h", 32'(bus.hour_num), 11);
    bus.mode_24h = 1'b1; step(1); chk("hn_24h", 32'(bus.hour_num), 23);
    ld = 1'b0;

    // Mode walk through all set states and back to RUN
    load(10, 0, 1, 1, 1, 0);
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      press_mode();
      chk($sformatf("walk_mode_sel_%0d", i), 32'(bus.mode_sel), 32'(i % 7));
      if (i < 7) chk($sformatf("walk_no_tick_%0d", i), 32'(bus.en), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("rerun_wait_%0d", i), 32'(bus.en), 0);
    end
    step(1);
    chk("rerun_tick_en", 32'(bus.en), 32'h01);
    chk("rerun_tick_inc", 32'(bus.inc), 32'h01);

    // SET_MIN: up, down, both
    load(10, 30, 1, 1, 1, 0);
    do_reset();
    press_mode();
    press_mode();
    chk("smin_mode_sel", 32'(bus.mode_sel), 2);
    pulse_up();
    chk("smin_up_en", 32'(bus.en), 32'h02);
    chk("smin_up_inc", 32'(bus.inc), 32'h02);
    chk("smin_up_dec", 32'(bus.dec), 0);
    step(1);
    chk("smin_up_once", 32'(bus.en), 0);
    chk("smin_up_val", 32'(bus.minute), 31);
    bus.btn_down = 1'b1; step(1); bus.btn_down = 1'b0; step(1);
    chk("smin_dn_en", 32'(bus.en), 32'h02);
    chk("smin_dn_dec", 32'(bus.dec), 32'h02);
    chk("smin_dn_inc", 32'(bus.inc), 0);
    step(1);
    chk("smin_dn_val", 32'(bus.minute), 30);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; step(1);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; step(1);
    chk("smin_both_en", 32'(bus.en), 0);
    step(1);
    chk("smin_both_en2", 32'(bus.en), 0);
    chk("smin_both_val", 32'(bus.minute), 30);
    chk("smin_sec_frozen", 32'(bus.second), 10);

    // SET_MON clamp: 31 Jan year 0 -> Feb, day pulled to 29
    load(10, 0, 1, 31, 1, 0);
    do_reset();
    for (int i = 0; i < 5; i++) press_mode();
    chk("smon_mode_sel", 32'(bus.mode_sel), 5);
    pulse_up();
    chk("cl_mon_en", 32'(bus.en), 32'h10);
    chk("cl_mon_inc", 32'(bus.inc), 32'h10);
    chk("cl_in_clamp", 32'(bus.mode_sel), 0);
    step(1);
    chk("cl_wait_en", 32'(bus.en), 0);
    chk("cl_month", 32'(bus.month), 2);
    step(1);
    chk("cl_dec1_en", 32'(bus.en), 32'h08);
    chk("cl_dec1_dec", 32'(bus.dec), 32'h08);
    step(1);
    chk("cl_gap_en", 32'(bus.en), 0);
    chk("cl_day30", 32'(bus.day), 30);
    step(1);
    chk("cl_dec2_dec", 32'(bus.dec), 32'h08);
    step(1);
    chk("cl_day29", 32'(bus.day), 29);
    step(1);
    chk("cl_return", 32'(bus.mode_sel), 5);
    chk("cl_done_en", 32'(bus.en), 0);

    // Reset in the middle of a clamp
    load(10, 0, 1, 31, 1, 0);
    do_reset();
    for (int i = 0; i < 5; i++) press_mode();
    pulse_up();
    step(2);
    chk("rc_dec_seen", 32'(bus.dec), 32'h08);
    reset_n = 1'b0;
    step(1);
    chk("rc_mode_sel", 32'(bus.mode_sel), 0);
    chk("rc_en", 32'(bus.en), 0);
    chk("rc_dec", 32'(bus.dec), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("rc_quiet_%0d", i), 32'(bus.en), 0);
    end
    step(1);
    chk("rc_tick_en", 32'(bus.en), 32'h01);
    chk("rc_tick_dec", 32'(bus.dec), 0);

    // Hour clamp when leaving SET_HOUR after switching to 12 h
    bus.mode_24h = 1'b1;
    load(10, 0, 15, 5, 3, 1);
    do_reset();
    for (int i = 0; i < 3; i++) press_mode();
    chk("hc_mode_sel", 32'(bus.mode_sel), 3);
    bus.mode_24h = 1'b0;
    press_mode();
    chk("hc_in_clamp", 32'(bus.mode_sel), 0);
    decs = 0;
    k    = 0;
    while ((bus.mode_sel != 3'd4) && (k < 20)) begin
      step(1);
      if ((bus.en == 6'h04) && (bus.dec == 6'h04)) decs++;
      k++;
    end
    chk("hc_return", 32'(bus.mode_sel), 4);
    chk("hc_dec_count", 32'(decs), 4);
    chk("hc_hour", 32'(bus.hour), 11);

    // Button held through reset gives no edge
    bus.btn_mode = 1'b1;
    reset_n      = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("held_btn_mode_sel", 32'(bus.mode_sel), 0);
    bus.btn_mode = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
